fetch_stage: RTL

- Instruction-fetch stage and IF/ID pipeline buffer for the pipelined MIPS core.
- Owns the PC register and drives the word address into the asynchronous Instruction_Mem.
- Computes the jump and branch targets from redirect requests issued by the decode stage.
- Presents PC+4, the instruction and a valid bit to decode through a stallable, flushable IF/ID register.

---
 rtl/fetch_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, addresses the asynchronous instruction memory, and applies
// jump/branch redirects requested by decode for the instruction held in IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_AW    = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Stall,
    input  logic             JToPC,
    input  logic [25:0]      Jump_index,
    input  logic             PCSrc,
    input  logic [15:0]      Branch_offset,
    output logic [IM_AW-1:0] IM_Addr,
    input  logic [31:0]      IM_Instr,
    output logic [31:0]      PC,
    output logic [31:0]      IFID_PC4,
    output logic [31:0]      IFID_Instr,
    output logic             IFID_Valid,
    output logic [31:0]      Fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // Redirect requests only count when IF/ID holds a real instruction.
    assign redirect      = ifid_valid_q && (JToPC || PCSrc);
    assign pc_plus4      = pc_q + 32'd4;
    assign jump_target   = {ifid_pc4_q[31:28], Jump_index, 2'b00};
    assign branch_target = ifid_pc4_q + {{14{Branch_offset[15]}}, Branch_offset, 2'b00};

    // Next-state selection: redirect beats stall, stall beats normal fetch.
    always_comb begin
        pc_d          = pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect) begin
            // Jump wins over branch; the instruction fetched this cycle is dropped.
            pc_d         = JToPC ? jump_target : branch_target;
            ifid_pc4_d   = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (!Stall) begin
            pc_d          = pc_plus4;
            ifid_pc4_d    = pc_plus4;
            ifid_instr_d  = IM_Instr;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // PC and IF/ID state registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q          <= RESET_PC;
            ifid_pc4_q    <= 32'h0;
            ifid_instr_q  <= 32'h0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign IM_Addr     = pc_q[IM_AW+1:2];
    assign PC          = pc_q;
    assign IFID_PC4    = ifid_pc4_q;
    assign IFID_Instr  = ifid_instr_q;
    assign IFID_Valid  = ifid_valid_q;
    assign Fetch_count = fetch_count_q;

endmodule
